ecdsa_sign_ctrl: RTL and testbench

Parametrised ECDSA signing sequencer that turns a message hash and private key into a signature (r, s) over a short-Weierstrass curve. It fetches a nonce k from the TRNG with a request/valid handshake and drives the team's external scalar-multiplier (montgomeryLadder) and modular-inverter (eeageneric) cores through start/done handshakes. It performs hash truncation, modular reduction and both mod-n products internally with a bit-serial modular multiplier. It retries with a fresh nonce on degenerate results, and it sits between the security-engine command decoder and the ECC arithmetic cores.

---
 rtl/ecdsa_sign_ctrl_if.sv | 65 ++++++
 rtl/ecdsa_sign_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_ecdsa_sign_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecdsa_sign_ctrl_if.sv
// Bundle of the signing command/result signals and the TRNG, point-multiplier
// and inverter handshakes that surround the ECDSA signing sequencer.
interface ecdsa_sign_ctrl_if #(
  parameter int WIDTH      = 64,
  parameter int HASH_WIDTH = 512,
  parameter int MAX_TRY    = 4
);
  localparam int AW = $clog2(MAX_TRY + 1);

  // command side
  logic                  start;
  logic [HASH_WIDTH-1:0] hash;
  logic [WIDTH-1:0]      priv_key;
  logic [WIDTH-1:0]      p;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [WIDTH-1:0]      gx;
  logic [WIDTH-1:0]      gy;
  logic [WIDTH-1:0]      n;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [WIDTH-1:0]      r;
  logic [WIDTH-1:0]      s;
  logic [AW-1:0]         attempts;

  // TRNG
  logic                  nonce_req;
  logic                  nonce_valid;
  logic [WIDTH-1:0]      nonce;

  // point multiplier (curve parameters forwarded from the latched copy)
  logic                  pm_start;
  logic [WIDTH-1:0]      pm_k;
  logic [WIDTH-1:0]      pm_p;
  logic [WIDTH-1:0]      pm_a;
  logic [WIDTH-1:0]      pm_b;
  logic [WIDTH-1:0]      pm_gx;
  logic [WIDTH-1:0]      pm_gy;
  logic                  pm_done;
  logic [WIDTH-1:0]      pm_x;
  logic                  pm_inf;

  // modular inverter
  logic                  inv_start;
  logic [WIDTH-1:0]      inv_x;
  logic                  inv_done;
  logic [WIDTH-1:0]      inv_res;

  modport master (
    input  start, hash, priv_key, p, a, b, gx, gy, n,
    input  nonce_valid, nonce, pm_done, pm_x, pm_inf, inv_done, inv_res,
    output busy, done, fail, r, s, attempts,
    output nonce_req, pm_start, pm_k, pm_p, pm_a, pm_b, pm_gx, pm_gy,
    output inv_start, inv_x
  );

  modport slave (
    output start, hash, priv_key, p, a, b, gx, gy, n,
    output nonce_valid, nonce, pm_done, pm_x, pm_inf, inv_done, inv_res,
    input  busy, done, fail, r, s, attempts,
    input  nonce_req, pm_start, pm_k, pm_p, pm_a, pm_b, pm_gx, pm_gy,
    input  inv_start, inv_x
  );
endinterface

// File: rtl/ecdsa_sign_ctrl.sv
// ECDSA signing sequencer: truncates/reduces the hash, fetches a nonce,
// runs the external point multiplier and inverter in parallel, then forms
// s = k^-1 (e + r*d) mod n with an internal bit-serial modular multiplier.
// Degenerate nonces/results trigger a retry up to MAX_TRY attempts.
module ecdsa_sign_ctrl #(
  parameter int WIDTH      = 64,
  parameter int HASH_WIDTH = 512,
  parameter int MAX_TRY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  ecdsa_sign_ctrl_if.master bus
);
  localparam int AW = $clog2(MAX_TRY + 1);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_NONCE, S_PMINV, S_RRED,
    S_MUL1, S_ADD, S_MUL2, S_CHK, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [AW-1:0]    att_q, att_d;
  logic             nreq_q, nreq_d;
  logic             pm_start_q, pm_start_d;
  logic             inv_start_q, inv_start_d;

  // secrets and intermediates that are wiped at the end of every operation
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] kinv_q, kinv_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] u_q, u_d;

  // working data
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gx_q, gx_d;
  logic [WIDTH-1:0] gy_q, gy_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] px_q, px_d;
  logic             inf_q, inf_d;
  logic [WIDTH-1:0] rw_q, rw_d;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             to_retry, to_fail, to_ok;
  logic [WIDTH+1:0] step_w, red_w, sum_w;
  logic [AW-1:0]    att_inc;

  // only the top WIDTH bits of the digest take part in signing
  logic             unused_hash;
  assign unused_hash = ^bus.hash;

  // x mod m for x < 2m
  function automatic logic [WIDTH+1:0] cond_sub(input logic [WIDTH+1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] mw;
    mw = {2'b00, m};
    return (x >= mw) ? (x - mw) : x;
  endfunction

  // one MSB-first multiplier step: acc = 2*acc (+ a) mod m
  function automatic logic [WIDTH+1:0] mod_step(input logic [WIDTH+1:0] acc,
                                                input logic [WIDTH-1:0] av,
                                                input logic             mbit,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] v;
    v = cond_sub(acc << 1, m);
    if (mbit) v = cond_sub(v + {2'b00, av}, m);
    return v;
  endfunction

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.r         = r_q;
  assign bus.s         = s_q;
  assign bus.attempts  = att_q;
  assign bus.nonce_req = nreq_q;
  assign bus.pm_start  = pm_start_q;
  assign bus.pm_k      = k_q;
  assign bus.pm_p      = p_q;
  assign bus.pm_a      = a_q;
  assign bus.pm_b      = b_q;
  assign bus.pm_gx     = gx_q;
  assign bus.pm_gy     = gy_q;
  assign bus.inv_start = inv_start_q;
  assign bus.inv_x     = k_q;

  // Next-state, handshake and datapath decisions for the signing sequence.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    r_d         = r_q;
    s_d         = s_q;
    att_d       = att_q;
    nreq_d      = nreq_q;
    pm_start_d  = pm_start_q;
    inv_start_d = inv_start_q;
    k_d         = k_q;
    kinv_d      = kinv_q;
    d_d         = d_q;
    t_d         = t_q;
    u_d         = u_q;
    z_d         = z_q;
    n_d         = n_q;
    p_d         = p_q;
    a_d         = a_q;
    b_d         = b_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    e_d         = e_q;
    px_d        = px_q;
    inf_d       = inf_q;
    rw_d        = rw_q;
    sw_d        = sw_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    to_retry    = 1'b0;
    to_fail     = 1'b0;
    to_ok       = 1'b0;
    step_w      = mod_step(acc_q, ma_q, mb_q[WIDTH-1], n_q);
    red_w       = cond_sub({2'b00, px_q}, n_q);
    sum_w       = cond_sub({2'b00, e_q} + {2'b00, t_q}, n_q);
    att_inc     = att_q + AW'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          att_d   = '0;
          z_d     = bus.hash[HASH_WIDTH-1 -: WIDTH];
          d_d     = bus.priv_key;
          n_d     = bus.n;
          p_d     = bus.p;
          a_d     = bus.a;
          b_d     = bus.b;
          gx_d    = bus.gx;
          gy_d    = bus.gy;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        e_d = WIDTH'(cond_sub({2'b00, z_q}, n_q));
        if ((d_q == '0) || (d_q >= n_q)) begin
          to_fail = 1'b1;
        end else begin
          nreq_d  = 1'b1;
          state_d = S_NONCE;
        end
      end
      S_NONCE: begin
        // request drops for a cycle after every accepted nonce
        if (!nreq_q) begin
          nreq_d = 1'b1;
        end else if (bus.nonce_valid) begin
          nreq_d = 1'b0;
          att_d  = att_inc;
          if ((bus.nonce != '0) && (bus.nonce < n_q)) begin
            k_d         = bus.nonce;
            pm_start_d  = 1'b1;
            inv_start_d = 1'b1;
            state_d     = S_PMINV;
          end else if (att_inc == AW'(MAX_TRY)) begin
            to_fail = 1'b1;
          end
        end
      end
      S_PMINV: begin
        if (pm_start_q && bus.pm_done) begin
          pm_start_d = 1'b0;
          px_d       = bus.pm_x;
          inf_d      = bus.pm_inf;
        end
        if (inv_start_q && bus.inv_done) begin
          inv_start_d = 1'b0;
          kinv_d      = bus.inv_res;
        end
        if (!pm_start_q && !inv_start_q) begin
          if (inf_q) to_retry = 1'b1;
          else       state_d  = S_RRED;
        end
      end
      S_RRED: begin
        rw_d = WIDTH'(red_w);
        if (red_w == '0) begin
          to_retry = 1'b1;
        end else begin
          acc_d   = '0;
          ma_d    = WIDTH'(red_w);
          mb_d    = d_q;
          cnt_d   = '0;
          state_d = S_MUL1;
        end
      end
      S_MUL1: begin
        acc_d = step_w;
        mb_d  = mb_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          t_d     = WIDTH'(step_w);
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        u_d     = WIDTH'(sum_w);
        acc_d   = '0;
        ma_d    = kinv_q;
        mb_d    = WIDTH'(sum_w);
        cnt_d   = '0;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        acc_d = step_w;
        mb_d  = mb_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sw_d    = WIDTH'(step_w);
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (sw_q == '0) to_retry = 1'b1;
        else            to_ok    = 1'b1;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (to_retry) begin
      if (att_q == AW'(MAX_TRY)) begin
        to_fail = 1'b1;
      end else begin
        nreq_d  = 1'b1;
        state_d = S_NONCE;
      end
    end
    if (to_ok) begin
      r_d     = rw_q;
      s_d     = sw_q;
      done_d  = 1'b1;
      state_d = S_DONE;
    end
    if (to_fail) begin
      r_d     = '0;
      s_d     = '0;
      done_d  = 1'b1;
      fail_d  = 1'b1;
      state_d = S_DONE;
    end
    if (state_d == S_DONE) begin
      k_d    = '0;
      kinv_d = '0;
      d_d    = '0;
      t_d    = '0;
      u_d    = '0;
    end
  end

  // Control, outputs and secret material: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      r_q         <= '0;
      s_q         <= '0;
      att_q       <= '0;
      nreq_q      <= 1'b0;
      pm_start_q  <= 1'b0;
      inv_start_q <= 1'b0;
      k_q         <= '0;
      kinv_q      <= '0;
      d_q         <= '0;
      t_q         <= '0;
      u_q         <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      r_q         <= r_d;
      s_q         <= s_d;
      att_q       <= att_d;
      nreq_q      <= nreq_d;
      pm_start_q  <= pm_start_d;
      inv_start_q <= inv_start_d;
      k_q         <= k_d;
      kinv_q      <= kinv_d;
      d_q         <= d_d;
      t_q         <= t_d;
      u_q         <= u_d;
    end
  end

  // Working datapath registers: always rewritten before use, no reset needed.
  always_ff @(posedge clk) begin
    z_q   <= z_d;
    n_q   <= n_d;
    p_q   <= p_d;
    a_q   <= a_d;
    b_q   <= b_d;
    gx_q  <= gx_d;
    gy_q  <= gy_d;
    e_q   <= e_d;
    px_q  <= px_d;
    inf_q <= inf_d;
    rw_q  <= rw_d;
    sw_q  <= sw_d;
    ma_q  <= ma_d;
    mb_q  <= mb_d;
    acc_q <= acc_d;
    cnt_q <= cnt_d;
  end
endmodule

// File: tb/tb_ecdsa_sign_ctrl.sv
// Directed bench for ecdsa_sign_ctrl on the toy curve p=17, a=2, b=2,
// G=(5,1), n=19 with WIDTH=5, HASH_WIDTH=16. Two instances (MAX_TRY 4 and 2)
// share the TRNG, point-multiplier and inverter models; sel picks the active one.
module tb_ecdsa_sign_ctrl;
  localparam int W  = 5;
  localparam int HW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ecdsa_sign_ctrl_if #(.WIDTH(W), .HASH_WIDTH(HW), .MAX_TRY(4)) b1 ();
  ecdsa_sign_ctrl_if #(.WIDTH(W), .HASH_WIDTH(HW), .MAX_TRY(2)) b2 ();

  ecdsa_sign_ctrl #(.WIDTH(W), .HASH_WIDTH(HW), .MAX_TRY(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.master));
  ecdsa_sign_ctrl #(.WIDTH(W), .HASH_WIDTH(HW), .MAX_TRY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.master));

  logic        sel = 1'b0;
  logic        start_v = 1'b0;
  logic [15:0] hash_v = '0;
  logic [4:0]  key_v = '0, nonce_v = '0, px_v = '0, ires_v = '0;
  logic        nv = 1'b0, nv_force = 1'b0, pd = 1'b0, pd_force = 1'b0;
  logic        pinf_v = 1'b0, idn = 1'b0;

  assign b1.start = start_v & ~sel;
  assign b2.start = start_v & sel;
  assign b1.hash = hash_v;       assign b2.hash = hash_v;
  assign b1.priv_key = key_v;    assign b2.priv_key = key_v;
  assign b1.p = 5'd17;  assign b2.p = 5'd17;
  assign b1.a = 5'd2;   assign b2.a = 5'd2;
  assign b1.b = 5'd2;   assign b2.b = 5'd2;
  assign b1.gx = 5'd5;  assign b2.gx = 5'd5;
  assign b1.gy = 5'd1;  assign b2.gy = 5'd1;
  assign b1.n = 5'd19;  assign b2.n = 5'd19;
  assign b1.nonce_valid = (nv | nv_force) & ~sel;
  assign b2.nonce_valid = (nv | nv_force) & sel;
  assign b1.nonce = nonce_v;     assign b2.nonce = nonce_v;
  assign b1.pm_done = (pd | pd_force) & ~sel;
  assign b2.pm_done = (pd | pd_force) & sel;
  assign b1.pm_x = px_v;         assign b2.pm_x = px_v;
  assign b1.pm_inf = pinf_v;     assign b2.pm_inf = pinf_v;
  assign b1.inv_done = idn & ~sel;
  assign b2.inv_done = idn & sel;
  assign b1.inv_res = ires_v;    assign b2.inv_res = ires_v;

  wire       m_busy = sel ? b2.busy      : b1.busy;
  wire       m_done = sel ? b2.done      : b1.done;
  wire       m_fail = sel ? b2.fail      : b1.fail;
  wire       m_nreq = sel ? b2.nonce_req : b1.nonce_req;
  wire       m_pms  = sel ? b2.pm_start  : b1.pm_start;
  wire       m_ivs  = sel ? b2.inv_start : b1.inv_start;
  wire [4:0] m_r    = sel ? b2.r         : b1.r;
  wire [4:0] m_s    = sel ? b2.s         : b1.s;
  wire [4:0] m_pmk  = sel ? b2.pm_k      : b1.pm_k;
  wire [4:0] m_pmp  = sel ? b2.pm_p      : b1.pm_p;
  wire [4:0] m_invx = sel ? b2.inv_x     : b1.inv_x;
  wire [2:0] m_att  = sel ? {1'b0, b2.attempts} : b1.attempts;

  logic [4:0] nq[$];
  logic [4:0] pxq[$];
  bit         infq[$];
  int         pm_lat = 3, inv_lat = 2;
  int         pm_t = 0, inv_t = 0, pm_cnt = -1, inv_cnt = -1;
  bit         pm_run = 0, inv_run = 0, req_seen = 0;
  logic [4:0] pmk_seen = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] modinv19(input logic [4:0] x);
    for (int i = 1; i < 19; i++)
      if ((int'(x) * i) % 19 == 1) return 5'(i);
    return 5'd0;
  endfunction

  // TRNG model: answers a raised request with the next queued nonce
  always @(negedge clk) begin
    nv = 1'b0;
    if (m_nreq) begin
      req_seen = 1;
      if (nq.size() > 0) begin
        nv = 1'b1;
        nonce_v = nq.pop_front();
      end
    end
  end

  // point-multiplier model: one done pulse pm_lat cycles after start rises
  always @(negedge clk) begin
    pd = 1'b0;
    if (!m_pms) pm_run = 0;
    else if (!pm_run) begin pm_run = 1; pm_cnt = pm_lat; end
    else if (pm_cnt == 0) begin
      pd = 1'b1; pm_cnt = -1; pm_t = cyc; pmk_seen = m_pmk;
      px_v   = (pxq.size() > 0)  ? pxq.pop_front()  : 5'd0;
      pinf_v = (infq.size() > 0) ? infq.pop_front() : 1'b0;
    end
    else if (pm_cnt > 0) pm_cnt--;
  end

  // inverter model: returns the true inverse mod 19 after inv_lat cycles
  always @(negedge clk) begin
    idn = 1'b0;
    if (!m_ivs) inv_run = 0;
    else if (!inv_run) begin inv_run = 1; inv_cnt = inv_lat; end
    else if (inv_cnt == 0) begin
      idn = 1'b1; inv_cnt = -1; inv_t = cyc; ires_v = modinv19(m_invx);
    end
    else if (inv_cnt > 0) inv_cnt--;
  end

  logic [4:0] cap_r, cap_s, cap_pmp;
  int cap_fail, cap_att, cap_cyc, cap_b1, cap_n1, cap_n2, t0;

  task automatic clear_models();
    nq.delete(); pxq.delete(); infq.delete();
  endtask

  task automatic run_sign(input logic [15:0] h, input logic [4:0] d, input int again);
    bit ok;
    ok = 0;
    hash_v = h; key_v = d; req_seen = 0; start_v = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 0) begin cap_b1 = int'(m_busy); cap_n1 = int'(m_nreq); end
      if (i == 1) cap_n2 = int'(m_nreq);
      if (m_done) begin
        ok = 1;
        cap_r = m_r; cap_s = m_s; cap_fail = int'(m_fail);
        cap_att = int'(m_att); cap_cyc = cyc; cap_pmp = m_pmp;
        break;
      end
      start_v = (i == again);
      @(negedge clk);
    end
    start_v = 1'b0;
    if (!ok) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  int lat;
  int bad;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctrl", int'({m_busy, m_done, m_fail, m_nreq, m_pms, m_ivs}), 0);
    check("rst_rs", int'({m_r, m_s}), 0);
    check("rst_att", int'(m_att), 0);
    rst = 1'b0;
    @(negedge clk);

    // nonce_valid with no request outstanding
    nv_force = 1'b1; @(negedge clk); nv_force = 1'b0; @(negedge clk);
    check("stray_nv", int'({m_busy, m_att}), 0);

    // nominal: e=7, r=7, t=11, u=18, s=2*18 mod 19=17; inverter first
    clear_models(); nq.push_back(5'd10); pxq.push_back(5'd7); infq.push_back(1'b0);
    pm_lat = 4; inv_lat = 1;
    run_sign(16'hD000, 5'd7, -1);
    check("nom_busy1", cap_b1, 1);
    check("nom_req1", cap_n1, 0);
    check("nom_req2", cap_n2, 1);
    check("nom_r", int'(cap_r), 7);
    check("nom_s", int'(cap_s), 17);
    check("nom_fail", cap_fail, 0);
    check("nom_att", cap_att, 1);
    lat = cap_cyc - ((pm_t > inv_t) ? pm_t : inv_t);
    check("nom_lat", lat, 15);
    check("nom_pmk", int'(pmk_seen), 10);
    check("nom_pmp", int'(cap_pmp), 17);
    check("nom_after", int'({m_busy, m_done}), 0);

    // invalid nonces 0 and 19 then 10; simultaneous dones; stray start mid-run
    clear_models(); nq = '{5'd0, 5'd19, 5'd10}; pxq.push_back(5'd7);
    pm_lat = 2; inv_lat = 2;
    run_sign(16'hD000, 5'd7, 6);
    check("inv_r", int'(cap_r), 7);
    check("inv_s", int'(cap_s), 17);
    check("inv_att", cap_att, 3);
    lat = cap_cyc - ((pm_t > inv_t) ? pm_t : inv_t);
    check("inv_lat", lat, 15);

    // r = 0 on first attempt; multiplier finishes first
    clear_models(); nq = '{5'd7, 5'd10}; pxq = '{5'd0, 5'd7};
    pm_lat = 1; inv_lat = 4;
    run_sign(16'hD000, 5'd7, -1);
    check("r0_r", int'(cap_r), 7);
    check("r0_s", int'(cap_s), 17);
    check("r0_att", cap_att, 2);
    lat = cap_cyc - ((pm_t > inv_t) ? pm_t : inv_t);
    check("r0_lat", lat, 15);

    // point at infinity on first attempt
    clear_models(); nq = '{5'd10, 5'd10}; pxq = '{5'd7, 5'd7}; infq = '{1'b1, 1'b0};
    pm_lat = 2; inv_lat = 1;
    run_sign(16'hD000, 5'd7, -1);
    check("inf_rs", int'({cap_r, cap_s}), int'({5'd7, 5'd17}));
    check("inf_att", cap_att, 2);

    // every nonce out of range: exhausts MAX_TRY=4
    clear_models(); nq = '{5'd0, 5'd0, 5'd19, 5'd0};
    run_sign(16'hD000, 5'd7, -1);
    check("exh_fail", cap_fail, 1);
    check("exh_rs", int'({cap_r, cap_s}), 0);
    check("exh_att", cap_att, 4);

    // bad keys: no nonce request, done+fail within 3 cycles
    clear_models();
    run_sign(16'hD000, 5'd0, -1);
    check("d0_fail", cap_fail, 1);
    check("d0_lat", int'((cap_cyc - t0) <= 3), 1);
    check("d0_req", int'(req_seen), 0);
    run_sign(16'hD000, 5'd19, -1);
    check("dn_fail", cap_fail, 1);
    check("dn_lat", int'((cap_cyc - t0) <= 3), 1);
    check("dn_req", int'(req_seen), 0);
    check("dn_rs", int'({cap_r, cap_s}), 0);

    // s = 0 twice on the MAX_TRY=2 instance: e=8, u=19 -> 0
    sel = 1'b1;
    clear_models(); nq = '{5'd10, 5'd10}; pxq = '{5'd7, 5'd7};
    pm_lat = 2; inv_lat = 1;
    run_sign(16'h4000, 5'd7, -1);
    check("s0_fail", cap_fail, 1);
    check("s0_rs", int'({cap_r, cap_s}), 0);
    check("s0_att", cap_att, 2);
    sel = 1'b0;

    // reset while the multiplier is still working, then a late pm_done
    clear_models(); nq.push_back(5'd10); pxq.push_back(5'd7);
    pm_lat = 30; inv_lat = 1;
    hash_v = 16'hD000; key_v = 5'd7; start_v = 1'b1;
    @(negedge clk); start_v = 1'b0;
    for (int i = 0; i < 20 && !m_pms; i++) @(negedge clk);
    check("mid_pms", int'(m_pms), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("mid_ctrl", int'({m_busy, m_done, m_fail, m_nreq, m_pms, m_ivs}), 0);
    check("mid_rs_att", int'({m_r, m_s, m_att}), 0);
    pd_force = 1'b1; @(negedge clk); pd_force = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bad |= int'({m_busy, m_done, m_pms, m_nreq});
      @(negedge clk);
    end
    check("mid_late", bad, 0);
    clear_models(); nq.push_back(5'd10); pxq.push_back(5'd7);
    pm_lat = 3; inv_lat = 2;
    run_sign(16'hD000, 5'd7, -1);
    check("post_r", int'(cap_r), 7);
    check("post_s", int'(cap_s), 17);
    check("post_att", cap_att, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
